// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Minutes:seconds stopwatch with start/pause and clear push buttons.
// Buttons are synchronised and edge-detected into one-cycle press pulses
// that drive an IDLE/RUN/PAUSE controller. A prescaler divides the clock
// down to one tick per second while running; each tick advances a
// 00:00..99:59 count that wraps with a one-cycle rollover pulse.
//
// Ports
//   clock           system clock, all state changes on its rising edge
//   reset           synchronous, active-high reset
//   btn_start_stop  raw start/pause button (asynchronous, active-high)
//   btn_clear       raw clear button (asynchronous, active-high)
//   minutes[6:0]    elapsed minutes, 0..99
//   seconds[6:0]    elapsed seconds, 0..59
//   running         high while counting
//   rollover        one-cycle pulse when the count wraps 99:59 -> 00:00
// -----------------------------------------------------------------------------
module stopwatch_counter #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic       running,
  output logic       rollover
);

  localparam int unsigned     PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0]      SEC_MAX   = 7'd59;
  localparam logic [6:0]      MIN_MAX   = 7'd99;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_e;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic [1:0] ss_sync_q;
  logic [1:0] clr_sync_q;
  logic       ss_hist_q;
  logic       clr_hist_q;
  logic [1:0] fill_q;
  logic       ss_pulse;
  logic       clr_pulse;

  // The synchronisers come out of reset holding 0, which is not a real
  // button level. fill_q keeps the history flops at 1 until the first
  // genuinely sampled level reaches the end of the synchroniser, so a
  // button held through reset release never looks like a fresh press.
  always_ff @(posedge clock) begin
    if (reset) begin
      ss_sync_q  <= '0;
      clr_sync_q <= '0;
      ss_hist_q  <= 1'b1;
      clr_hist_q <= 1'b1;
      fill_q     <= '0;
    end else begin
      ss_sync_q  <= {ss_sync_q[0], btn_start_stop};
      clr_sync_q <= {clr_sync_q[0], btn_clear};
      ss_hist_q  <= fill_q[1] ? ss_sync_q[1]  : 1'b1;
      clr_hist_q <= fill_q[1] ? clr_sync_q[1] : 1'b1;
      fill_q     <= {fill_q[0], 1'b1};
    end
  end

  assign ss_pulse  = ss_sync_q[1]  & ~ss_hist_q;
  assign clr_pulse = clr_sync_q[1] & ~clr_hist_q;

  // ---------------------------------------------------------------------------
  // Controller and count datapath
  // ---------------------------------------------------------------------------
  state_e        state_q,  state_d;
  logic [PW-1:0] presc_q,  presc_d;
  logic [6:0]    sec_q,    sec_d;
  logic [6:0]    min_q,    min_d;
  logic          roll_q,   roll_d;
  logic          tick;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      roll_q  <= roll_d;
    end
  end

  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

  // The tick is applied first and the button transition second, so a
  // start/stop press that coincides with a tick still lets that second
  // count. Clear is applied last so it overrides everything.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    roll_d  = 1'b0;

    if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      if (sec_q == SEC_MAX) begin
        sec_d = '0;
        if (min_q == MIN_MAX) begin
          min_d  = '0;
          roll_d = 1'b1;
        end else begin
          min_d = min_q + 7'd1;
        end
      end else begin
        sec_d = sec_q + 7'd1;
      end
    end

    unique case (state_q)
      ST_IDLE:  if (ss_pulse) state_d = ST_RUN;
      ST_RUN:   if (ss_pulse) state_d = ST_PAUSE;
      ST_PAUSE: if (ss_pulse) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    if (clr_pulse) begin
      state_d = ST_IDLE;
      presc_d = '0;
      sec_d   = '0;
      min_d   = '0;
      roll_d  = 1'b0;
    end
  end

  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign running  = (state_q == ST_RUN);
  assign rollover = roll_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

  localparam int TD = 4;

  logic       clock;
  logic       reset;
  logic       btn_start_stop;
  logic       btn_clear;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic       running;
  logic       rollover;

  stopwatch_counter #(.TICK_DIV(TD)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .minutes        (minutes),
    .seconds        (seconds),
    .running        (running),
    .rollover       (rollover)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: elapsed time kept as a single count of seconds plus
  // cycles into the current second; button presses from the history of
  // values sampled at each edge (a press is a 0->1 seen two edges late).
  int       m_total = 0;
  int       m_phase = 0;
  bit       m_run   = 1'b0;
  bit       m_roll  = 1'b0;
  bit [2:0] h_ss    = '1;
  bit [2:0] h_clr   = '1;

  always @(posedge clock) begin
    bit p_ss, p_clr;
    if (reset) begin
      h_ss    = '1;
      h_clr   = '1;
      m_run   = 1'b0;
      m_total = 0;
      m_phase = 0;
      m_roll  = 1'b0;
    end else begin
      p_ss  = h_ss[1]  & ~h_ss[2];
      p_clr = h_clr[1] & ~h_clr[2];
      h_ss  = {h_ss[1:0],  btn_start_stop};
      h_clr = {h_clr[1:0], btn_clear};
      m_roll = 1'b0;
      if (m_run) begin
        m_phase++;
        if (m_phase == TD) begin
          m_phase = 0;
          m_total = (m_total + 1) % 6000;
          m_roll  = (m_total == 0);
        end
      end
      if (p_ss) m_run = !m_run;
      if (p_clr) begin
        m_run   = 1'b0;
        m_total = 0;
        m_phase = 0;
        m_roll  = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_minutes",  int'(minutes),  m_total / 60);
      check("model_seconds",  int'(seconds),  m_total % 60);
      check("model_running",  int'(running),  int'(m_run));
      check("model_rollover", int'(rollover), int'(m_roll));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    cycles(3);
    chk_en = 1'b1;
    check("rst_minutes", int'(minutes), 0);
    check("rst_seconds", int'(seconds), 0);
    check("rst_running", int'(running), 0);
    check("rst_rollover", int'(rollover), 0);
    reset = 1'b0;
    cycles(4);

    // Start: sampled at edge N, running from N+2, seconds step every 4 edges
    btn_start_stop = 1'b1;
    cycles(1);
    btn_start_stop = 1'b0;
    cycles(1);
    check("s1_not_yet_running", int'(running), 0);
    cycles(1);
    check("s1_running", int'(running), 1);
    cycles(3);
    check("s1_sec0_at3", int'(seconds), 0);
    cycles(1);
    check("s1_sec1", int'(seconds), 1);
    cycles(4);
    check("s1_sec2", int'(seconds), 2);

    // 00:59 -> 01:00
    cycles(57 * TD);
    check("s2_min_before", int'(minutes), 0);
    check("s2_sec_before", int'(seconds), 59);
    cycles(TD);
    check("s2_min_after", int'(minutes), 1);
    check("s2_sec_after", int'(seconds), 0);

    // Pause two cycles into a second, wait, resume
    cycles(3);
    btn_start_stop = 1'b1;
    cycles(1);
    btn_start_stop = 1'b0;
    check("s4_sec_at_tick", int'(seconds), 1);
    cycles(2);
    check("s4_paused", int'(running), 0);
    cycles(20);
    check("s4_hold_min", int'(minutes), 1);
    check("s4_hold_sec", int'(seconds), 1);
    btn_start_stop = 1'b1;
    cycles(1);
    btn_start_stop = 1'b0;
    cycles(2);
    check("s4_resumed", int'(running), 1);
    check("s4_sec_resume", int'(seconds), 1);
    cycles(1);
    check("s4_sec_resume1", int'(seconds), 1);
    cycles(1);
    check("s4_sec_resume2", int'(seconds), 2);

    // Clear and start/stop together at 05:17
    cycles(255 * TD);
    check("s5_min_517", int'(minutes), 5);
    check("s5_sec_517", int'(seconds), 17);
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    cycles(1);
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    cycles(2);
    check("s5_min_clr", int'(minutes), 0);
    check("s5_sec_clr", int'(seconds), 0);
    check("s5_run_clr", int'(running), 0);

    // Full wrap 99:59 -> 00:00
    btn_start_stop = 1'b1;
    cycles(1);
    btn_start_stop = 1'b0;
    cycles(2);
    check("s3_running", int'(running), 1);
    cycles(5999 * TD);
    check("s3_min_9959", int'(minutes), 99);
    check("s3_sec_9959", int'(seconds), 59);
    check("s3_roll_before", int'(rollover), 0);
    cycles(TD);
    check("s3_min_wrap", int'(minutes), 0);
    check("s3_sec_wrap", int'(seconds), 0);
    check("s3_roll_pulse", int'(rollover), 1);
    check("s3_still_running", int'(running), 1);
    cycles(1);
    check("s3_roll_gone", int'(rollover), 0);

    // Button held across reset release
    reset = 1'b1;
    btn_start_stop = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(10);
    check("s6_held_no_start", int'(running), 0);
    btn_start_stop = 1'b0;
    cycles(3);
    check("s6_released", int'(running), 0);
    btn_start_stop = 1'b1;
    cycles(1);
    btn_start_stop = 1'b0;
    cycles(2);
    check("s6_pressed_run", int'(running), 1);

    // Random buttons and occasional resets against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_start_stop = ~btn_start_stop;
      btn_clear = ($urandom_range(0, 79) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      cycles(1);
    end
    reset = 1'b0;
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter TICK_DIV, default 50000000, is the number of clock cycles per counted second (50 MHz board clock); legal range 2 to 2^26.
REQ-002 Port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port btn_start_stop, input, 1: raw start/pause push button, asynchronous to clock, active-high.
REQ-005 Port btn_clear, input, 1: raw clear push button, asynchronous to clock, active-high.
REQ-006 Port minutes, output, 7: elapsed minutes, binary, 0-99; feeds seven_segment_driver minutes input.
REQ-007 Port seconds, output, 7: elapsed seconds, binary, 0-59; feeds seven_segment_driver seconds input.
REQ-008 Port running, output, 1: high while the state is RUN.
REQ-009 Port rollover, output, 1: single-cycle pulse on wrap from 99:59 to 00:00.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer, then a rising-edge detector (history flop), producing a one-cycle press pulse.
REQ-011 A button sampled high at rising edge N SHALL first affect state and outputs at edge N+2; a held button SHALL produce exactly one pulse.
REQ-012 FSM states SHALL be IDLE, RUN and PAUSE; running = (state == RUN).
REQ-013 Transitions: IDLE + start_stop pulse -> RUN; RUN + start_stop pulse -> PAUSE; PAUSE + start_stop pulse -> RUN; any state + clear pulse -> IDLE.
REQ-014 On a clear pulse, minutes, seconds and the prescaler SHALL be zero at the same edge that enters IDLE.
REQ-015 Clear and start_stop pulses in the same cycle: clear SHALL win and the state SHALL end in IDLE.
REQ-016 Prescaler: counts 0 to TICK_DIV-1 only in RUN; on reaching TICK_DIV-1 it wraps to 0 and issues a one-cycle internal tick.
REQ-017 The prescaler SHALL hold its value in PAUSE, so a resumed count completes the partial second.
REQ-018 The first tick after IDLE->RUN SHALL occur exactly TICK_DIV cycles after the entry edge.
REQ-019 On a tick: seconds < 59 -> seconds+1; seconds == 59 -> seconds = 0 and minutes+1.
REQ-020 On a tick at 99:59: minutes = 0, seconds = 0, rollover = 1 for that cycle only, state stays RUN.
REQ-021 minutes and seconds SHALL be registered, change only on a tick, clear or reset, and never exceed 99 and 59.
REQ-022 A start_stop pulse in the same cycle as a tick SHALL let the tick complete its count and then apply the transition.

Reset
REQ-023 With reset high at a rising edge: state = IDLE, minutes = 0, seconds = 0, running = 0, rollover = 0, prescaler = 0, synchronizer flops = 0.
REQ-024 On reset, edge-detector history flops SHALL load 1, so a button held through reset release yields no pulse until it is released and pressed again.
REQ-025 Reset SHALL override every other input, including mid-count and mid-pulse.

Verification (TICK_DIV = 4)
REQ-026 Scenario 1: reset, then start_stop pulse -> running = 1 two edges after the button is sampled; seconds = 1 after 4 cycles, seconds = 2 after 8 cycles.
REQ-027 Scenario 2: run to 00:59, then one tick -> 01:00.
REQ-028 Scenario 3: run to 99:59, then one tick -> 00:00 with rollover high exactly one cycle and running still 1.
REQ-029 Scenario 4: pause 2 cycles into a second, idle 20 cycles, resume -> next increment 2 cycles after resume, with no count change while paused.
REQ-030 Scenario 5: clear and start_stop pressed in the same cycle while running at 05:17 -> IDLE, 00:00, running = 0.
REQ-031 Scenario 6: btn_start_stop held high across reset deassertion -> no start; release then press -> RUN.
